axi_slave_ram: RTL and testbench
================================

Name: axi_slave_ram

Overview:
Downstream AXI4 slave endpoint that consumes the bursts produced by a bus master (or a master after the interconnect) and backs them with an internal word-addressed register RAM. It gives simulation benches and bring-up builds a real target for master traffic. Write and read channels are independent, each with one outstanding transaction.

Parameters:
ID_WIDTH, 2, width of all ID fields; IDs are echoed unchanged.
ADDR_BASE, 32'h0000_0000, byte address of RAM word 0.
MEM_DEPTH, 256, RAM depth in 32-bit words; word index = (ADDR-ADDR_BASE)>>2.

Ports:
clk  in  1  single clock for all logic
rstn  in  1  asynchronous active-low reset
SLAVE_WR_ADDR_ID  in  ID_WIDTH  write transaction ID
SLAVE_WR_ADDR  in  32  write start byte address
SLAVE_WR_ADDR_LEN  in  8  beats minus 1
SLAVE_WR_ADDR_BURST  in  2  00 FIXED, 01 INCR, 10/11 unsupported
SLAVE_WR_ADDR_VALID  in  1  write address valid
SLAVE_WR_ADDR_READY  out  1  write address accepted
SLAVE_WR_DATA  in  32  write beat data
SLAVE_WR_STRB  in  4  byte enables, bit i -> DATA[8i+7:8i]
SLAVE_WR_DATA_LAST  in  1  final write beat
SLAVE_WR_DATA_VALID  in  1  write beat valid
SLAVE_WR_DATA_READY  out  1  write beat accepted
SLAVE_WR_BACK_ID  out  ID_WIDTH  echoed write ID
SLAVE_WR_BACK_RESP  out  2  00 OKAY, 10 SLVERR
SLAVE_WR_BACK_VALID  out  1  write response valid
SLAVE_WR_BACK_READY  in  1  master accepts response
SLAVE_RD_ADDR_ID  in  ID_WIDTH  read transaction ID
SLAVE_RD_ADDR  in  32  read start byte address
SLAVE_RD_ADDR_LEN  in  8  beats minus 1
SLAVE_RD_ADDR_BURST  in  2  as write burst
SLAVE_RD_ADDR_VALID  in  1  read address valid
SLAVE_RD_ADDR_READY  out  1  read address accepted
SLAVE_RD_BACK_ID  out  ID_WIDTH  echoed read ID
SLAVE_RD_DATA  out  32  read beat data
SLAVE_RD_DATA_RESP  out  2  per-beat 00 OKAY / 10 SLVERR
SLAVE_RD_DATA_LAST  out  1  final read beat
SLAVE_RD_DATA_VALID  out  1  read beat valid
SLAVE_RD_DATA_READY  in  1  master accepts beat

Behaviour:
- Reset (rstn low, asynchronous): both FSMs -> IDLE; every output 0, including both ADDR_READYs. RAM contents are not reset. ADDR_READYs are registered and rise the first clock after rstn deasserts. Reset mid-burst abandons the burst; no response is issued.
- Handshake: transfer occurs when VALID&READY are high at a rising edge. VALID outputs hold, and their payloads stay stable, until accepted.
- Write FSM: W_IDLE (WR_ADDR_READY=1) -> on AW handshake, latch ID/addr/len/burst, clear err -> W_DATA (WR_DATA_READY=1; each beat writes strobed bytes, then advances: INCR +1 word, FIXED hold) -> on beat with DATA_LAST=1 -> W_RESP (BACK_VALID=1, RESP=err?10:00) -> on BACK handshake -> W_IDLE. The next AW is acceptable the cycle after the response handshake.
- Write err is set by any of: unsupported burst (no beats written); a beat whose word index is <0 or >=MEM_DEPTH (that beat dropped); beat count != LEN+1. The burst always ends on DATA_LAST.
- Read FSM: R_IDLE (RD_ADDR_READY=1) -> on AR handshake at edge N -> R_DATA with RD_DATA_VALID=1 from edge N+1 (one-cycle registered RAM read). Each beat handshake loads the next beat, so streaming is back-to-back while RD_DATA_READY=1. LAST=1 on beat LEN; its handshake -> R_IDLE.
- Read RESP per beat: 10 with DATA=0 if the beat's index is out of range or the burst is unsupported; otherwise 00.
- Address arithmetic: low two address bits are ignored. INCR with index overflow becomes out-of-range; there is no wrap-around.
- Same-edge write and read of one word: the read returns the old data.
- Read and write FSMs run concurrently with no mutual blocking.

Test Plan:
- Reset then INCR write ID=1 addr 0x10 LEN=3 data 0xA0..0xA3 STRB=F, RESP handshake -> BACK_ID=1 RESP=00; INCR read addr 0x10 LEN=3 -> 0xA0..0xA3, LAST on 4th beat, RD_DATA_VALID first seen the edge after AR handshake.
- Write 0xFFFFFFFF to 0x0 then STRB=4'b0101 data 0x11223344 -> read 0x0 returns 0xFF22FF44.
- FIXED write addr 0x20 LEN=2 data 1,2,3 -> read 0x20 = 3; read 0x24 unchanged.
- Write at byte address 4*MEM_DEPTH-4 with LEN=1 -> RESP=10, first word written; read same LEN=1 -> beat0 RESP=00, beat1 RESP=10 DATA=0.
- Read LEN=7 with RD_DATA_READY toggling 1/0 -> DATA/LAST held stable while stalled, 8 beats in order; concurrent write burst completes unaffected.
- Assert rstn low mid-write (after 2 of 4 beats) -> all outputs 0 immediately, both READYs high one cycle after release, new burst completes normally.

Source files
------------

// File: rtl/axi_slave_ram.sv
// AXI4 slave endpoint backed by a word-addressed register RAM.
// Independent write and read channels, each with one outstanding burst.
module axi_slave_ram #(
    parameter int          ID_WIDTH  = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_DEPTH = 256
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ID_WIDTH-1:0] SLAVE_WR_ADDR_ID,
    input  logic [31:0]         SLAVE_WR_ADDR,
    input  logic [7:0]          SLAVE_WR_ADDR_LEN,
    input  logic [1:0]          SLAVE_WR_ADDR_BURST,
    input  logic                SLAVE_WR_ADDR_VALID,
    output logic                SLAVE_WR_ADDR_READY,
    input  logic [31:0]         SLAVE_WR_DATA,
    input  logic [3:0]          SLAVE_WR_STRB,
    input  logic                SLAVE_WR_DATA_LAST,
    input  logic                SLAVE_WR_DATA_VALID,
    output logic                SLAVE_WR_DATA_READY,
    output logic [ID_WIDTH-1:0] SLAVE_WR_BACK_ID,
    output logic [1:0]          SLAVE_WR_BACK_RESP,
    output logic                SLAVE_WR_BACK_VALID,
    input  logic                SLAVE_WR_BACK_READY,
    input  logic [ID_WIDTH-1:0] SLAVE_RD_ADDR_ID,
    input  logic [31:0]         SLAVE_RD_ADDR,
    input  logic [7:0]          SLAVE_RD_ADDR_LEN,
    input  logic [1:0]          SLAVE_RD_ADDR_BURST,
    input  logic                SLAVE_RD_ADDR_VALID,
    output logic                SLAVE_RD_ADDR_READY,
    output logic [ID_WIDTH-1:0] SLAVE_RD_BACK_ID,
    output logic [31:0]         SLAVE_RD_DATA,
    output logic [1:0]          SLAVE_RD_DATA_RESP,
    output logic                SLAVE_RD_DATA_LAST,
    output logic                SLAVE_RD_DATA_VALID,
    input  logic                SLAVE_RD_DATA_READY
);

    localparam int          AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [29:0] DEPTH = 30'(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t            w_state, w_state_next;
    logic                aw_ready;
    logic [ID_WIDTH-1:0] w_id;
    logic [29:0]         w_idx;
    logic                w_oor;
    logic [7:0]          w_len, w_cnt;
    logic [1:0]          w_burst;
    logic                w_err;
    logic                aw_hs, wr_hs, w_ok;
    logic [32:0]         aw_diff;
    logic [30:0]         w_idx_inc;

    // Word index is the byte offset from the base; bit 32 flags an address below the base.
    assign aw_diff   = {1'b0, SLAVE_WR_ADDR} - {1'b0, ADDR_BASE};
    assign aw_hs     = SLAVE_WR_ADDR_VALID & aw_ready;
    assign wr_hs     = SLAVE_WR_DATA_VALID & SLAVE_WR_DATA_READY;
    assign w_ok      = ~w_burst[1] & ~w_oor & (w_idx < DEPTH);
    assign w_idx_inc = {1'b0, w_idx} + 31'd1;

    always_comb begin
        w_state_next        = w_state;
        SLAVE_WR_DATA_READY = 1'b0;
        SLAVE_WR_BACK_VALID = 1'b0;
        SLAVE_WR_BACK_RESP  = 2'b00;
        unique case (w_state)
            W_IDLE: if (aw_hs) w_state_next = W_DATA;
            W_DATA: begin
                SLAVE_WR_DATA_READY = 1'b1;
                if (SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_LAST) w_state_next = W_RESP;
            end
            W_RESP: begin
                SLAVE_WR_BACK_VALID = 1'b1;
                SLAVE_WR_BACK_RESP  = {w_err, 1'b0};
                if (SLAVE_WR_BACK_READY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // NOTE: ADDR_READY is registered from the next state so it stays low through reset and rises one clock after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
        end else begin
            w_state  <= w_state_next;
            aw_ready <= (w_state_next == W_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_oor   <= 1'b0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= SLAVE_WR_ADDR_ID;
            w_idx   <= aw_diff[31:2];
            w_oor   <= aw_diff[32];
            w_len   <= SLAVE_WR_ADDR_LEN;
            w_burst <= SLAVE_WR_ADDR_BURST;
            w_cnt   <= '0;
            w_err   <= SLAVE_WR_ADDR_BURST[1];
        end else if (wr_hs) begin
            w_cnt <= w_cnt + 8'd1;
            // LAST must coincide exactly with beat LEN; early or late LAST both flag an error.
            if (!w_ok || (SLAVE_WR_DATA_LAST != (w_cnt == w_len))) w_err <= 1'b1;
            if (w_burst == 2'b01) begin
                w_idx <= w_idx_inc[29:0];
                w_oor <= w_oor | w_idx_inc[30];
            end
        end
    end

    // NOTE: the RAM array is deliberately not reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_hs && w_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (SLAVE_WR_STRB[b]) mem[w_idx[AW-1:0]][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
            end
        end
    end

    assign SLAVE_WR_ADDR_READY = aw_ready;
    assign SLAVE_WR_BACK_ID    = w_id;

    // ---------------- read channel ----------------
    r_state_t            r_state, r_state_next;
    logic                ar_ready;
    logic [ID_WIDTH-1:0] r_id;
    logic [29:0]         r_idx, lk_idx;
    logic                r_oor, lk_oor, lk_ok;
    logic [7:0]          r_len, r_cnt;
    logic [1:0]          r_burst, lk_burst;
    logic [31:0]         rd_data;
    logic [1:0]          rd_resp;
    logic                rd_last;
    logic                ar_hs, rd_hs, rd_load;
    logic [32:0]         ar_diff;
    logic [30:0]         r_idx_inc;
    logic                unused_low;

    assign ar_diff    = {1'b0, SLAVE_RD_ADDR} - {1'b0, ADDR_BASE};
    assign unused_low = ^{aw_diff[1:0], ar_diff[1:0]};
    assign ar_hs      = SLAVE_RD_ADDR_VALID & ar_ready;
    assign rd_hs      = SLAVE_RD_DATA_VALID & SLAVE_RD_DATA_READY;
    assign rd_load    = ar_hs | (rd_hs & ~rd_last);
    assign r_idx_inc  = {1'b0, r_idx} + 31'd1;

    // Index of the beat to fetch: the start address on AR, else the successor of the current beat.
    always_comb begin
        lk_idx   = r_idx;
        lk_oor   = r_oor;
        lk_burst = r_burst;
        if (ar_hs) begin
            lk_idx   = ar_diff[31:2];
            lk_oor   = ar_diff[32];
            lk_burst = SLAVE_RD_ADDR_BURST;
        end else if (r_burst == 2'b01) begin
            lk_idx = r_idx_inc[29:0];
            lk_oor = r_oor | r_idx_inc[30];
        end
    end

    assign lk_ok = ~lk_burst[1] & ~lk_oor & (lk_idx < DEPTH);

    always_comb begin
        r_state_next        = r_state;
        SLAVE_RD_DATA_VALID = 1'b0;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_state_next = R_DATA;
            R_DATA: begin
                SLAVE_RD_DATA_VALID = 1'b1;
                if (SLAVE_RD_DATA_READY && rd_last) r_state_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
        end else begin
            r_state  <= r_state_next;
            ar_ready <= (r_state_next == R_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_id    <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            rd_data <= '0;
            rd_resp <= '0;
            rd_last <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= SLAVE_RD_ADDR_ID;
                r_len   <= SLAVE_RD_ADDR_LEN;
                r_burst <= SLAVE_RD_ADDR_BURST;
                r_cnt   <= '0;
                rd_last <= (SLAVE_RD_ADDR_LEN == 8'd0);
            end else if (rd_hs) begin
                if (rd_last) begin
                    rd_last <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + 8'd1;
                    rd_last <= ((r_cnt + 8'd1) == r_len);
                end
            end
            if (rd_load) begin
                r_idx   <= lk_idx;
                r_oor   <= lk_oor;
                rd_data <= lk_ok ? mem[lk_idx[AW-1:0]] : 32'd0;
                rd_resp <= lk_ok ? 2'b00 : 2'b10;
            end else if (rd_hs) begin
                rd_data <= '0;
                rd_resp <= '0;
            end
        end
    end

    assign SLAVE_RD_ADDR_READY = ar_ready;
    assign SLAVE_RD_BACK_ID    = r_id;
    assign SLAVE_RD_DATA       = rd_data;
    assign SLAVE_RD_DATA_RESP  = rd_resp;
    assign SLAVE_RD_DATA_LAST  = rd_last;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Scoreboard bench for axi_slave_ram: drivers push expected responses/beats,
// negedge monitors compare and pop them as the DUT presents outputs.
module tb_axi_slave_ram;

    localparam int          IDW   = 2;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [1:0]  FIXED = 2'b00;
    localparam logic [1:0]  INCR  = 2'b01;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [IDW-1:0] SLAVE_WR_ADDR_ID;
    logic [31:0]    SLAVE_WR_ADDR;
    logic [7:0]     SLAVE_WR_ADDR_LEN;
    logic [1:0]     SLAVE_WR_ADDR_BURST;
    logic           SLAVE_WR_ADDR_VALID;
    logic           SLAVE_WR_ADDR_READY;
    logic [31:0]    SLAVE_WR_DATA;
    logic [3:0]     SLAVE_WR_STRB;
    logic           SLAVE_WR_DATA_LAST;
    logic           SLAVE_WR_DATA_VALID;
    logic           SLAVE_WR_DATA_READY;
    logic [IDW-1:0] SLAVE_WR_BACK_ID;
    logic [1:0]     SLAVE_WR_BACK_RESP;
    logic           SLAVE_WR_BACK_VALID;
    logic           SLAVE_WR_BACK_READY;
    logic [IDW-1:0] SLAVE_RD_ADDR_ID;
    logic [31:0]    SLAVE_RD_ADDR;
    logic [7:0]     SLAVE_RD_ADDR_LEN;
    logic [1:0]     SLAVE_RD_ADDR_BURST;
    logic           SLAVE_RD_ADDR_VALID;
    logic           SLAVE_RD_ADDR_READY;
    logic [IDW-1:0] SLAVE_RD_BACK_ID;
    logic [31:0]    SLAVE_RD_DATA;
    logic [1:0]     SLAVE_RD_DATA_RESP;
    logic           SLAVE_RD_DATA_LAST;
    logic           SLAVE_RD_DATA_VALID;
    logic           SLAVE_RD_DATA_READY;

    always #5 clk = ~clk;

    axi_slave_ram #(.ID_WIDTH(IDW), .ADDR_BASE(BASE), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .SLAVE_WR_ADDR_ID(SLAVE_WR_ADDR_ID), .SLAVE_WR_ADDR(SLAVE_WR_ADDR),
        .SLAVE_WR_ADDR_LEN(SLAVE_WR_ADDR_LEN), .SLAVE_WR_ADDR_BURST(SLAVE_WR_ADDR_BURST),
        .SLAVE_WR_ADDR_VALID(SLAVE_WR_ADDR_VALID), .SLAVE_WR_ADDR_READY(SLAVE_WR_ADDR_READY),
        .SLAVE_WR_DATA(SLAVE_WR_DATA), .SLAVE_WR_STRB(SLAVE_WR_STRB),
        .SLAVE_WR_DATA_LAST(SLAVE_WR_DATA_LAST), .SLAVE_WR_DATA_VALID(SLAVE_WR_DATA_VALID),
        .SLAVE_WR_DATA_READY(SLAVE_WR_DATA_READY), .SLAVE_WR_BACK_ID(SLAVE_WR_BACK_ID),
        .SLAVE_WR_BACK_RESP(SLAVE_WR_BACK_RESP), .SLAVE_WR_BACK_VALID(SLAVE_WR_BACK_VALID),
        .SLAVE_WR_BACK_READY(SLAVE_WR_BACK_READY),
        .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID), .SLAVE_RD_ADDR(SLAVE_RD_ADDR),
        .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN), .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST),
        .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID), .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY),
        .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID), .SLAVE_RD_DATA(SLAVE_RD_DATA),
        .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP), .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST),
        .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID), .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY)
    );

    logic [45:0] all_outs;
    assign all_outs = {SLAVE_WR_ADDR_READY, SLAVE_WR_DATA_READY, SLAVE_WR_BACK_ID,
                       SLAVE_WR_BACK_RESP, SLAVE_WR_BACK_VALID, SLAVE_RD_ADDR_READY,
                       SLAVE_RD_BACK_ID, SLAVE_RD_DATA, SLAVE_RD_DATA_RESP,
                       SLAVE_RD_DATA_LAST, SLAVE_RD_DATA_VALID};

    typedef struct packed {logic [IDW-1:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct packed {logic [IDW-1:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] model [DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Monitors compare whatever is presented; the entry is retired only on handshake,
    // so a stalled beat or response is re-checked every cycle it is held.
    always @(negedge clk) begin
        if (rstn && SLAVE_WR_BACK_VALID) begin
            if (b_q.size() == 0) check("b_unexpected", SLAVE_WR_BACK_VALID, 0);
            else begin
                check("b_id", SLAVE_WR_BACK_ID, b_q[0].id);
                check("b_resp", SLAVE_WR_BACK_RESP, b_q[0].resp);
                if (SLAVE_WR_BACK_READY) void'(b_q.pop_front());
            end
        end
        if (rstn && SLAVE_RD_DATA_VALID) begin
            if (r_q.size() == 0) check("r_unexpected", SLAVE_RD_DATA_VALID, 0);
            else begin
                check("r_id", SLAVE_RD_BACK_ID, r_q[0].id);
                check("r_data", SLAVE_RD_DATA, r_q[0].data);
                check("r_resp", SLAVE_RD_DATA_RESP, r_q[0].resp);
                check("r_last", SLAVE_RD_DATA_LAST, r_q[0].last);
                if (SLAVE_RD_DATA_READY) void'(r_q.pop_front());
            end
        end
    end

    task automatic wait_post();
        @(posedge clk);
        #1;
    endtask

    function automatic longint word_of(input logic [31:0] addr);
        return (longint'(addr) - longint'(BASE)) >>> 2;
    endfunction

    task automatic send_aw(input logic [IDW-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit done = 0;
        SLAVE_WR_ADDR_ID    = id;
        SLAVE_WR_ADDR       = addr;
        SLAVE_WR_ADDR_LEN   = len;
        SLAVE_WR_ADDR_BURST = burst;
        SLAVE_WR_ADDR_VALID = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            done = SLAVE_WR_ADDR_READY;
            wait_post();
        end
        SLAVE_WR_ADDR_VALID = 1'b0;
        check("aw_accept", done, 1);
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input bit last);
        bit done = 0;
        SLAVE_WR_DATA       = data;
        SLAVE_WR_STRB       = strb;
        SLAVE_WR_DATA_LAST  = last;
        SLAVE_WR_DATA_VALID = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            done = SLAVE_WR_DATA_READY;
            wait_post();
        end
        SLAVE_WR_DATA_VALID = 1'b0;
        SLAVE_WR_DATA_LAST  = 1'b0;
        check("w_accept", done, 1);
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input logic [31:0] data0,
                            input logic [3:0] strb, input int bdelay);
        longint start = word_of(addr);
        bit     err   = burst[1] || (nbeats != int'(len) + 1);
        bit     done  = 0;
        for (int i = 0; i < nbeats; i++) begin
            longint      idx = start + ((burst == INCR) ? i : 0);
            logic [31:0] d   = data0 + 32'(i);
            if (!burst[1]) begin
                if (idx < 0 || idx >= DEPTH) err = 1;
                else for (int b = 0; b < 4; b++)
                    if (strb[b]) model[int'(idx)][8*b +: 8] = d[8*b +: 8];
            end
        end
        b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        send_aw(id, addr, len, burst);
        for (int i = 0; i < nbeats; i++) send_beat(data0 + 32'(i), strb, i == nbeats - 1);
        repeat (bdelay) wait_post();
        SLAVE_WR_BACK_READY = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            done = SLAVE_WR_BACK_VALID;
            wait_post();
        end
        SLAVE_WR_BACK_READY = 1'b0;
        check("b_accept", done, 1);
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
        longint start = word_of(addr);
        bit     done  = 0;
        bit     fin   = 0;
        for (int i = 0; i <= int'(len); i++) begin
            longint idx = start + ((burst == INCR) ? i : 0);
            bit     ok  = !burst[1] && idx >= 0 && idx < DEPTH;
            r_q.push_back('{id: id, data: ok ? model[int'(idx)] : 32'd0,
                            resp: ok ? 2'b00 : 2'b10, last: (i == int'(len))});
        end
        SLAVE_RD_ADDR_ID    = id;
        SLAVE_RD_ADDR       = addr;
        SLAVE_RD_ADDR_LEN   = len;
        SLAVE_RD_ADDR_BURST = burst;
        SLAVE_RD_ADDR_VALID = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (SLAVE_RD_ADDR_READY) begin
                check("rd_valid_pre", SLAVE_RD_DATA_VALID, 0);
                done = 1;
            end
            wait_post();
        end
        SLAVE_RD_ADDR_VALID = 1'b0;
        check("ar_accept", done, 1);
        check("rd_valid_first", SLAVE_RD_DATA_VALID, 1);
        for (int c = 0; c < 300 && !fin; c++) begin
            SLAVE_RD_DATA_READY = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            fin = SLAVE_RD_DATA_VALID && SLAVE_RD_DATA_READY && SLAVE_RD_DATA_LAST;
            wait_post();
        end
        SLAVE_RD_DATA_READY = 1'b0;
        check("rd_done", fin, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        SLAVE_WR_ADDR_ID = '0;  SLAVE_WR_ADDR = '0;  SLAVE_WR_ADDR_LEN = '0;
        SLAVE_WR_ADDR_BURST = '0;  SLAVE_WR_ADDR_VALID = 1'b0;
        SLAVE_WR_DATA = '0;  SLAVE_WR_STRB = '0;  SLAVE_WR_DATA_LAST = 1'b0;
        SLAVE_WR_DATA_VALID = 1'b0;  SLAVE_WR_BACK_READY = 1'b0;
        SLAVE_RD_ADDR_ID = '0;  SLAVE_RD_ADDR = '0;  SLAVE_RD_ADDR_LEN = '0;
        SLAVE_RD_ADDR_BURST = '0;  SLAVE_RD_ADDR_VALID = 1'b0;  SLAVE_RD_DATA_READY = 1'b0;

        repeat (2) wait_post();
        check("rst_outs", all_outs, 0);
        rstn = 1'b1;
        check("rst_ready_held", {SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY}, 2'b00);
        wait_post();
        check("rst_ready_rise", {SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY}, 2'b11);

        // Basic INCR write/read round trip
        do_write(2'd1, 32'h10, 8'd3, INCR, 4, 32'hA0, 4'hF, 2);
        do_read(2'd2, 32'h10, 8'd3, INCR, 0);

        // Byte strobes merge into existing word
        do_write(2'd0, 32'h0, 8'd0, INCR, 1, 32'hFFFF_FFFF, 4'hF, 0);
        do_write(2'd3, 32'h0, 8'd0, INCR, 1, 32'h1122_3344, 4'b0101, 1);
        do_read(2'd0, 32'h0, 8'd0, INCR, 0);

        // FIXED burst overwrites one word; neighbour untouched
        do_write(2'd1, 32'h24, 8'd0, INCR, 1, 32'hCAFE_F00D, 4'hF, 0);
        do_write(2'd2, 32'h20, 8'd2, FIXED, 3, 32'd1, 4'hF, 0);
        do_read(2'd1, 32'h20, 8'd1, INCR, 0);

        // Burst running off the end of the RAM
        do_write(2'd1, 32'(4 * DEPTH - 4), 8'd1, INCR, 2, 32'hB0, 4'hF, 0);
        do_read(2'd2, 32'(4 * DEPTH - 4), 8'd1, INCR, 0);

        // Beat-count mismatch and unsupported burst types
        do_write(2'd0, 32'h60, 8'd0, INCR, 2, 32'hC0, 4'hF, 0);
        do_write(2'd3, 32'h70, 8'd1, 2'b10, 2, 32'hD0, 4'hF, 0);
        do_read(2'd3, 32'h60, 8'd1, INCR, 0);
        do_read(2'd1, 32'h70, 8'd0, 2'b11, 0);

        // Stalled read stream with a concurrent write
        do_write(2'd0, 32'h40, 8'd7, INCR, 8, 32'h5000_0000, 4'hF, 0);
        fork
            do_read(2'd2, 32'h40, 8'd7, INCR, 1);
            do_write(2'd1, 32'h80, 8'd3, INCR, 4, 32'h8000, 4'hF, 3);
        join
        do_read(2'd3, 32'h80, 8'd3, INCR, 0);

        // Reset in the middle of a write burst: first two beats already in RAM
        model[64] = 32'h7700;
        model[65] = 32'h7701;
        send_aw(2'd2, 32'h100, 8'd3, INCR);
        send_beat(32'h7700, 4'hF, 0);
        send_beat(32'h7701, 4'hF, 0);
        rstn = 1'b0;
        #1;
        check("rst_mid_outs", all_outs, 0);
        b_q.delete();
        r_q.delete();
        repeat (2) wait_post();
        rstn = 1'b1;
        check("rst_mid_ready_held", {SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY}, 2'b00);
        wait_post();
        check("rst_mid_ready_rise", {SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY}, 2'b11);
        do_write(2'd1, 32'h140, 8'd3, INCR, 4, 32'h9000, 4'hF, 1);
        do_read(2'd0, 32'h140, 8'd3, INCR, 0);
        do_read(2'd1, 32'h100, 8'd1, INCR, 0);

        repeat (2) wait_post();
        check("b_q_drained", b_q.size(), 0);
        check("r_q_drained", r_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
